// File: rtl/dht11_uart_reporter_pkg.sv
// dht11_pkg: shared types and constants for the DHT11 UART reporter.
//   - ASCII constants used to build the report line
//   - line lengths for good and corrupt readings
//   - FSM state enums for the line sequencer and the byte transmitter
//   - reading_t: one captured sensor reading
//   - dec_digit(): ASCII digit of a byte printed as 3-digit decimal
package dht11_pkg;

  localparam logic [7:0] CH_H   = 8'h48;
  localparam logic [7:0] CH_T   = 8'h54;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_E   = 8'h45;
  localparam logic [7:0] CH_R   = 8'h52;
  localparam logic [7:0] CH_0   = 8'h30;

  localparam int LINE_LEN_OK  = 19;
  localparam int LINE_LEN_ERR = 5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT, ST_NEXT_CHAR, ST_DONE
  } top_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       ok;
  } reading_t;

  // pos 0 = hundreds, 1 = tens, 2 = ones
  function automatic logic [7:0] dec_digit(input logic [7:0] v, input logic [1:0] pos);
    logic [7:0] d;
    case (pos)
      2'd0:    d = v / 8'd100;
      2'd1:    d = (v / 8'd10) % 8'd10;
      default: d = v % 8'd10;
    endcase
    return CH_0 + d;
  endfunction

endpackage

// File: rtl/dht11_uart_reporter_uart_tx.sv
// uart_tx_byte: 8N1 serial transmitter for one byte.
//   clk, rst_n   : clock, asynchronous active-low reset
//   tx_start     : 1-clk request, accepted only when idle; tx_data latched then
//   uart_tx      : serial line, idle high
//   tx_done      : 1-clk pulse near the end of the stop bit
//   tx_busy      : high while a frame is on the line
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       uart_tx,
  output logic       tx_done,
  output logic       tx_busy
);
  import dht11_pkg::*;

  localparam logic [15:0] C_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_DONE = 16'(CLKS_PER_BIT - 2);

  tx_state_t   r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        w_bit_end;

  assign w_bit_end = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_cnt <= '0;
          if (tx_start) begin
            r_shift <= tx_data;
            r_tx    <= 1'b0;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= TX_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= TX_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx = r_tx;
  assign tx_busy = (r_state != TX_IDLE);
  // Fires in the second-to-last stop cycle: the sequencer's NEXT_CHAR/LOAD
  // hops then overlap the tail of the stop bit, so the next start bit lands
  // exactly 2 clk after the stop bit ends.
  assign tx_done = (r_state == TX_STOP) && (r_cnt == C_DONE);

endmodule

// File: rtl/dht11_uart_reporter.sv
// dht11_uart_reporter: prints each DHT11 reading as an ASCII line on a UART.
//   clk, rst_n       : 50 MHz clock, asynchronous active-low reset
//   sample_valid     : 1-clk pulse qualifying the reading inputs
//   hum_int/hum_dec  : humidity bytes
//   temp_int/temp_dec: temperature bytes
//   checksum_ok      : 1 = good reading ("H...T...\r\n"), 0 = "ERR\r\n"
//   uart_tx          : 8N1 serial output, idle high
//   busy             : high whenever the line sequencer is not idle
//   overrun          : sticky, a pending reading was overwritten
//   lines_sent       : completed line count, wraps
module dht11_uart_reporter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [7:0]  hum_int,
  input  logic [7:0]  hum_dec,
  input  logic [7:0]  temp_int,
  input  logic [7:0]  temp_dec,
  input  logic        checksum_ok,
  output logic        uart_tx,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] lines_sent
);
  import dht11_pkg::*;

  top_state_t  r_state, w_next;
  reading_t    r_cap, r_pend, w_in;
  logic        r_pend_vld;
  logic [4:0]  r_idx, w_last_idx;
  logic [7:0]  r_char, w_char;
  logic        r_overrun;
  logic [15:0] r_lines;
  logic        w_tx_start, w_tx_done, w_tx_busy, w_done_exit;

  assign w_in       = {hum_int, hum_dec, temp_int, temp_dec, checksum_ok};
  assign w_last_idx = r_cap.ok ? 5'(LINE_LEN_OK - 1) : 5'(LINE_LEN_ERR - 1);
  // DONE holds until the transmitter has fully released the line, so the
  // line count and busy only drop once the last stop bit is complete.
  assign w_done_exit = (r_state == ST_DONE) && !w_tx_busy;

  // Character generator: digits come straight off the capture registers.
  always_comb begin
    w_char = CH_LF;
    if (r_cap.ok) begin
      case (r_idx)
        5'd0:  w_char = CH_H;
        5'd1:  w_char = dec_digit(r_cap.hum_int, 2'd0);
        5'd2:  w_char = dec_digit(r_cap.hum_int, 2'd1);
        5'd3:  w_char = dec_digit(r_cap.hum_int, 2'd2);
        5'd4:  w_char = CH_DOT;
        5'd5:  w_char = dec_digit(r_cap.hum_dec, 2'd0);
        5'd6:  w_char = dec_digit(r_cap.hum_dec, 2'd1);
        5'd7:  w_char = dec_digit(r_cap.hum_dec, 2'd2);
        5'd8:  w_char = CH_SP;
        5'd9:  w_char = CH_T;
        5'd10: w_char = dec_digit(r_cap.temp_int, 2'd0);
        5'd11: w_char = dec_digit(r_cap.temp_int, 2'd1);
        5'd12: w_char = dec_digit(r_cap.temp_int, 2'd2);
        5'd13: w_char = CH_DOT;
        5'd14: w_char = dec_digit(r_cap.temp_dec, 2'd0);
        5'd15: w_char = dec_digit(r_cap.temp_dec, 2'd1);
        5'd16: w_char = dec_digit(r_cap.temp_dec, 2'd2);
        5'd17: w_char = CH_CR;
        default: w_char = CH_LF;
      endcase
    end else begin
      case (r_idx)
        5'd0:    w_char = CH_E;
        5'd1:    w_char = CH_R;
        5'd2:    w_char = CH_R;
        5'd3:    w_char = CH_CR;
        default: w_char = CH_LF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    case (r_state)
      ST_IDLE:      if (sample_valid) w_next = ST_LOAD;
      ST_LOAD:      w_next = ST_SEND;
      ST_SEND: begin
        w_tx_start = 1'b1;
        w_next     = ST_WAIT;
      end
      ST_WAIT:      if (w_tx_done) w_next = (r_idx == w_last_idx) ? ST_DONE : ST_NEXT_CHAR;
      ST_NEXT_CHAR: w_next = ST_LOAD;
      ST_DONE:      if (!w_tx_busy) w_next = (r_pend_vld || sample_valid) ? ST_LOAD : ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_idx      <= '0;
      r_char     <= '0;
      r_overrun  <= 1'b0;
      r_lines    <= '0;
    end else begin
      case (r_state)
        ST_LOAD:      r_char <= w_char;
        ST_NEXT_CHAR: r_idx  <= r_idx + 5'd1;
        ST_DONE:      if (!w_tx_busy) r_lines <= r_lines + 16'd1;
        default: ;
      endcase
      if (sample_valid) begin
        if (r_state == ST_IDLE) begin
          r_cap <= w_in;
          r_idx <= '0;
        end else if (w_done_exit) begin
          // Same-cycle arrival at DONE: it would land in the slot and be
          // consumed immediately, so it goes straight to capture.
          r_cap      <= w_in;
          r_idx      <= '0;
          r_pend_vld <= 1'b0;
          if (r_pend_vld) r_overrun <= 1'b1;
        end else begin
          r_pend     <= w_in;
          r_pend_vld <= 1'b1;
          if (r_pend_vld) r_overrun <= 1'b1;
        end
      end else if (w_done_exit && r_pend_vld) begin
        r_cap      <= r_pend;
        r_idx      <= '0;
        r_pend_vld <= 1'b0;
      end
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (w_tx_start),
    .tx_data  (r_char),
    .uart_tx  (uart_tx),
    .tx_done  (w_tx_done),
    .tx_busy  (w_tx_busy)
  );

  assign busy       = (r_state != ST_IDLE);
  assign overrun    = r_overrun;
  assign lines_sent = r_lines;

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// Scoreboard bench: expected characters are queued when a reading is driven
// and popped as the serial decoder recovers characters from uart_tx.
module tb_dht11_uart_reporter;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
  logic        checksum_ok = 1'b0;
  logic        uart_tx, busy, overrun;
  logic [15:0] lines_sent;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  dht11_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .hum_int      (hum_int),
    .hum_dec      (hum_dec),
    .temp_int     (temp_int),
    .temp_dec     (temp_dec),
    .checksum_ok  (checksum_ok),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .overrun      (overrun),
    .lines_sent   (lines_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic push_line(input logic [7:0] hi, hd, ti, td, input logic ok);
    string s;
    if (ok) s = $sformatf("H%03d.%03d T%03d.%03d", hi, hd, ti, td);
    else    s = "ERR";
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Drives a reading so that the next rising edge samples it; returns 1 time
  // unit after that edge.
  task automatic drive(input logic [7:0] hi, hd, ti, td, input logic ok, input logic sent);
    @(negedge clk);
    hum_int = hi; hum_dec = hd; temp_int = ti; temp_dec = td;
    checksum_ok = ok;
    sample_valid = 1'b1;
    if (sent) push_line(hi, hd, ti, td, ok);
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk("idle_reached", done, 1);
    repeat (80) @(negedge clk);
  endtask

  // Serial decoder: samples on falling edges, CPB samples per bit.
  initial begin : mon
    logic [9:0] bits;
    logic       wid_bad, ab, was_lf;
    logic [7:0] ch;
    int         g;
    forever begin
      @(negedge clk);
      while (rst_n && uart_tx === 1'b0) begin
        wid_bad = 1'b0; ab = 1'b0; bits = '0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n) begin ab = 1'b1; break; end
          if (k % CPB == 0) bits[k / CPB] = uart_tx;
          else if (uart_tx !== bits[k / CPB]) wid_bad = 1'b1;
        end
        if (ab) break;
        ch = bits[8:1];
        chk("start_bit", bits[0], 0);
        chk("stop_bit", bits[9], 1);
        chk("bit_width", wid_bad, 0);
        chk("char_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("char", ch, exp_q.pop_front());
        was_lf = (ch == 8'h0A);
        g = 0;
        @(negedge clk);
        while (rst_n && uart_tx === 1'b1 && g < 64) begin
          g++;
          @(negedge clk);
        end
        if (rst_n && uart_tx === 1'b0) begin
          if (was_lf) chk("line_gap", g + CPB, CPB + 3);
          else        chk("char_gap", g + CPB, CPB + 2);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_lines", lines_sent, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Good reading, with start-bit latency
    drive(8'd45, 8'd0, 8'd23, 8'd1, 1'b1, 1'b1);
    chk("lat_n0", uart_tx, 1);
    @(posedge clk); #1;
    chk("lat_n1", uart_tx, 1);
    chk("busy_n1", busy, 1);
    @(posedge clk); #1;
    chk("lat_n2", uart_tx, 0);
    wait_idle(4000);
    chk("t1_lines", lines_sent, 1);
    chk("t1_busy", busy, 0);

    // Corrupt reading
    drive(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    wait_idle(4000);
    chk("t2_lines", lines_sent, 2);

    // Digit boundaries, second reading held pending
    drive(8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    drive(8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    wait_idle(4000);
    chk("t3_lines", lines_sent, 4);
    chk("t3_ovr", overrun, 0);

    // Overwrite: A sent, B overwritten by C
    drive(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    drive(8'd5, 8'd6, 8'd7, 8'd8, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    drive(8'd9, 8'd10, 8'd11, 8'd12, 1'b1, 1'b1);
    wait_idle(4000);
    chk("t4_ovr", overrun, 1);
    chk("t4_lines", lines_sent, 6);

    // Reset during data bit 4 of the third character
    drive(8'd98, 8'd76, 8'd54, 8'd32, 1'b1, 1'b1);
    repeat (106) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", uart_tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lines", lines_sent, 0);
    chk("mid_rst_ovr", overrun, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    drive(8'd12, 8'd34, 8'd56, 8'd78, 1'b1, 1'b1);
    wait_idle(4000);
    chk("t5_lines", lines_sent, 1);
    chk("t5_ovr", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
